kw11x_timer: RTL and testbench

Parametrised multi-channel programmable interval timer, the successor of the single-bit KW11-L line clock on the F-11 processor board. It provides CHANNELS independent down-counters driven by a common tick, with per-channel CSR, preset buffer and live count. It sits on the board's I/O-page Wishbone slave path and raises one level-6 vectored interrupt with an internal channel-priority arbiter and vector handshake.

---
 rtl/kw11x_pkg.sv | 43 ++++
 rtl/kw11x_tickgen.sv | 56 +++++
 rtl/kw11x_timer.sv | 212 +++++++++++++++++++++
 tb/tb_kw11x_timer.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kw11x_pkg.sv
// kw11x_pkg: shared definitions for the kw11x_timer interval timer.
// CSR bit positions, register offsets inside a channel window, the
// interrupt handshake states and the I/O-page address decoder.
package kw11x_pkg;

  localparam int CSR_RUN    = 0;
  localparam int CSR_REPEAT = 3;
  localparam int CSR_IE     = 6;
  localparam int CSR_DONE   = 7;
  localparam int CSR_ERR    = 15;

  typedef enum logic [1:0] {
    REG_CSR = 2'd0,
    REG_CSB = 2'd1,
    REG_CTR = 2'd2,
    REG_NUL = 2'd3
  } kw11x_reg_e;

  typedef enum logic {
    IRQ_IDLE = 1'b0,
    IRQ_ACK  = 1'b1
  } kw11x_irq_e;

  typedef struct packed {
    logic       hit;
    logic [1:0] ch;
    kw11x_reg_e rg;
  } kw11x_dec_t;

  // Each channel owns an 8-byte window starting at base; byte bit 0 is ignored.
  function automatic kw11x_dec_t kw11x_decode(input logic [15:0] adr,
                                              input logic [15:0] base,
                                              input int unsigned nch);
    kw11x_dec_t d;
    logic [15:0] off;
    off   = adr - base;
    d.hit = (adr >= base) && ({16'd0, off} < 32'(8 * nch));
    d.ch  = off[4:3];
    d.rg  = kw11x_reg_e'(off[2:1]);
    return d;
  endfunction

endpackage

// File: rtl/kw11x_tickgen.sv
// kw11x_tickgen: common timebase for all timer channels.
// Default build: free-running prescaler wrapping every CLK_HZ/TICK_HZ clocks.
// With KW11X_EXT_TICK_EN defined: ext_tick is synchronised by two flops and
// each rising edge yields one registered 1-cycle tick, 3 clocks after the edge.
// Only dclo resets this block; bus INIT leaves the timebase running.
module kw11x_tickgen #(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 50
) (
  input  logic clk_p,
  input  logic dclo,
`ifdef KW11X_EXT_TICK_EN
  input  logic ext_tick,
`endif
  output logic tick
);

`ifdef KW11X_EXT_TICK_EN
  logic sync1, sync2, sync3, tick_r;

  // Two-flop synchroniser, edge history flop and registered rising-edge pulse
  always_ff @(posedge clk_p or posedge dclo) begin
    if (dclo) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync3  <= 1'b0;
      tick_r <= 1'b0;
    end else begin
      sync1  <= ext_tick;
      sync2  <= sync1;
      sync3  <= sync2;
      tick_r <= sync2 & ~sync3;
    end
  end

  assign tick = tick_r;
`else
  localparam int DIV = (CLK_HZ / TICK_HZ > 0) ? CLK_HZ / TICK_HZ : 1;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] cnt;

  // Prescaler counts 0..DIV-1 and wraps
  always_ff @(posedge clk_p or posedge dclo) begin
    if (dclo)
      cnt <= '0;
    else if (cnt == PW'(DIV - 1))
      cnt <= '0;
    else
      cnt <= cnt + PW'(1);
  end

  assign tick = (cnt == PW'(DIV - 1));
`endif

endmodule

// File: rtl/kw11x_timer.sv
// kw11x_timer: multi-channel programmable interval timer on the I/O-page
// Wishbone slave path with one vectored interrupt and a channel arbiter.
// Optional feature macro: KW11X_EXT_TICK_EN (external tick input instead of
// the internal prescaler).
module kw11x_timer import kw11x_pkg::*; #(
  parameter int          CHANNELS = 2,
  parameter int          CNT_W    = 16,
  parameter int          CLK_HZ   = 50000000,
  parameter int          TICK_HZ  = 50,
  parameter logic [15:0] BASE_ADR = 16'o172540,
  parameter logic [8:0]  VEC_BASE = 9'o100
) (
  input  logic        clk_p,
  input  logic        dclo,
  input  logic        bus_init,
  input  logic [15:0] wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic [1:0]  wb_sel_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  output logic        irq,
  input  logic        istb,
  output logic [8:0]  ivec,
  output logic        iack
`ifdef KW11X_EXT_TICK_EN
  ,
  input  logic        ext_tick
`endif
);

  logic                tick;
  kw11x_dec_t          dec;
  logic                ack_q;
  logic                bus_wr;
  logic [15:0]         rdata;
  logic [CHANNELS-1:0] req;
  logic [15:0]         csr_v [CHANNELS];
  logic [15:0]         csb_v [CHANNELS];
  logic [15:0]         ctr_v [CHANNELS];
  kw11x_irq_e          state, state_nxt;
  logic                grant;
  logic [1:0]          win_nxt, win_q;

  kw11x_tickgen #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_tickgen (
    .clk_p    (clk_p),
    .dclo     (dclo),
`ifdef KW11X_EXT_TICK_EN
    .ext_tick (ext_tick),
`endif
    .tick     (tick)
  );

  assign dec    = kw11x_decode(wb_adr_i, BASE_ADR, CHANNELS);
  assign bus_wr = wb_stb_i & wb_we_i & ~ack_q & dec.hit;

  // Single-cycle acknowledge: ack <= stb & ~ack, mapped addresses only
  always_ff @(posedge clk_p or posedge dclo) begin
    if (dclo)
      ack_q <= 1'b0;
    else if (bus_init)
      ack_q <= 1'b0;
    else
      ack_q <= wb_stb_i & ~ack_q & dec.hit;
  end

  assign wb_ack_o = ack_q;

  // Lowest-numbered pending channel is the arbitration winner
  always_comb begin
    win_nxt = '0;
    for (int i = CHANNELS - 1; i >= 0; i--)
      if (req[i]) win_nxt = 2'(i);
  end

  assign grant = (state == IRQ_IDLE) & istb & (|req);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic             run_q, rep_q, ie_q, done_q, err_q, req_q;
    logic [CNT_W-1:0] csb_q, ctr_q, reload;
    logic [15:0]      csb_ext, csb_m;
    logic             sel_ch, csr_wr, csb_wr, wr_lo, wr_hi;
    logic             start, expire, dec_ctr, grant_clr;

    assign sel_ch    = (dec.ch == 2'(g));
    assign csr_wr    = bus_wr & sel_ch & (dec.rg == REG_CSR);
    assign csb_wr    = bus_wr & sel_ch & (dec.rg == REG_CSB);
    assign wr_lo     = csr_wr & wb_sel_i[0];
    assign wr_hi     = csr_wr & wb_sel_i[1];
    assign reload    = (csb_q == '0) ? CNT_W'(1) : csb_q;
    assign start     = wr_lo & wb_dat_i[CSR_RUN] & ~run_q;
    assign expire    = tick & run_q & (ctr_q == CNT_W'(1));
    assign dec_ctr   = tick & run_q & (ctr_q > CNT_W'(1));
    assign grant_clr = grant & (win_nxt == 2'(g));
    assign csb_ext   = 16'(csb_q);
    assign csb_m     = {wb_sel_i[1] ? wb_dat_i[15:8] : csb_ext[15:8],
                        wb_sel_i[0] ? wb_dat_i[7:0]  : csb_ext[7:0]};

    // Channel state: expiry first, then bus writes override RUN/REPEAT/IE;
    // expiry keeps priority for setting DONE/ERR and for re-raising req
    always_ff @(posedge clk_p or posedge dclo) begin
      if (dclo) begin
        run_q  <= 1'b0;
        rep_q  <= 1'b0;
        ie_q   <= 1'b0;
        done_q <= 1'b0;
        err_q  <= 1'b0;
        req_q  <= 1'b0;
        csb_q  <= '0;
        ctr_q  <= '0;
      end else if (bus_init) begin
        run_q  <= 1'b0;
        rep_q  <= 1'b0;
        ie_q   <= 1'b0;
        done_q <= 1'b0;
        err_q  <= 1'b0;
        req_q  <= 1'b0;
        csb_q  <= '0;
        ctr_q  <= '0;
      end else begin
        if (expire) begin
          done_q <= 1'b1;
          if (done_q) err_q <= 1'b1;
          if (rep_q) begin
            ctr_q <= reload;
          end else begin
            ctr_q <= '0;
            run_q <= 1'b0;
          end
        end else if (dec_ctr) begin
          ctr_q <= ctr_q - CNT_W'(1);
        end
        if (wr_lo) begin
          run_q <= wb_dat_i[CSR_RUN];
          rep_q <= wb_dat_i[CSR_REPEAT];
          ie_q  <= wb_dat_i[CSR_IE];
          if (!expire) done_q <= wb_dat_i[CSR_DONE];
          if (start) ctr_q <= reload;
        end
        if (wr_hi && !wb_dat_i[CSR_ERR] && !(expire && done_q))
          err_q <= 1'b0;
        if (csb_wr)
          csb_q <= CNT_W'(csb_m);
        if (grant_clr)
          req_q <= 1'b0;
        if (expire && ie_q)
          req_q <= 1'b1;
        if (wr_lo && !wb_dat_i[CSR_IE])
          req_q <= 1'b0;
      end
    end

    assign req[g]   = req_q;
    assign csr_v[g] = {err_q, 7'd0, done_q, ie_q, 2'd0, rep_q, 2'd0, run_q};
    assign csb_v[g] = csb_ext;
    assign ctr_v[g] = 16'(ctr_q);
  end

  // Read multiplexer, forced to 0 outside the ack cycle for OR-merging
  always_comb begin
    rdata = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (dec.ch == 2'(i)) begin
        case (dec.rg)
          REG_CSR: rdata = csr_v[i];
          REG_CSB: rdata = csb_v[i];
          REG_CTR: rdata = ctr_v[i];
          default: rdata = '0;
        endcase
      end
    end
  end

  assign wb_dat_o = ack_q ? rdata : 16'd0;
  assign irq      = |req;

  // Interrupt handshake state register
  always_ff @(posedge clk_p or posedge dclo) begin
    if (dclo)
      state <= IRQ_IDLE;
    else if (bus_init)
      state <= IRQ_IDLE;
    else
      state <= state_nxt;
  end

  // Winner is frozen on the first istb cycle; gated by iack on the output
  always_ff @(posedge clk_p) begin
    if (grant) win_q <= win_nxt;
  end

  // Handshake next state: grant on istb with a pending request, release on istb low
  always_comb begin
    state_nxt = state;
    case (state)
      IRQ_IDLE: if (istb && (|req)) state_nxt = IRQ_ACK;
      IRQ_ACK:  if (!istb)          state_nxt = IRQ_IDLE;
      default:                      state_nxt = IRQ_IDLE;
    endcase
  end

  // Handshake outputs: vector valid only while iack is high
  always_comb begin
    iack = (state == IRQ_ACK);
    ivec = iack ? (VEC_BASE + 9'({win_q, 2'b00})) : 9'd0;
  end

endmodule

// File: tb/tb_kw11x_timer.sv
// tb_kw11x_timer: randomized scoreboard bench for kw11x_timer with a
// behavioural reference model of the register/interrupt rules.
module tb_kw11x_timer;

  localparam int          CH    = 2;
  localparam int          CW    = 16;
  localparam int          CLKHZ = 1000;
  localparam int          TCKHZ = 100;
  localparam int          DIV   = CLKHZ / TCKHZ;
  localparam logic [15:0] BASE  = 16'o172540;
  localparam logic [8:0]  VB    = 9'o100;

  logic        clk_p = 1'b0;
  logic        dclo, bus_init;
  logic [15:0] wb_adr_i, wb_dat_i, wb_dat_o;
  logic        wb_we_i, wb_stb_i, wb_ack_o;
  logic [1:0]  wb_sel_i;
  logic        irq, istb, iack;
  logic [8:0]  ivec;
`ifdef KW11X_EXT_TICK_EN
  logic        ext_tick;
`endif

  always #5 clk_p = ~clk_p;

  kw11x_timer #(
    .CHANNELS (CH),
    .CNT_W    (CW),
    .CLK_HZ   (CLKHZ),
    .TICK_HZ  (TCKHZ),
    .BASE_ADR (BASE),
    .VEC_BASE (VB)
  ) dut (
    .clk_p    (clk_p),
    .dclo     (dclo),
    .bus_init (bus_init),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_we_i  (wb_we_i),
    .wb_sel_i (wb_sel_i),
    .wb_stb_i (wb_stb_i),
    .wb_ack_o (wb_ack_o),
    .irq      (irq),
    .istb     (istb),
    .ivec     (ivec),
    .iack     (iack)
`ifdef KW11X_EXT_TICK_EN
    ,
    .ext_tick (ext_tick)
`endif
  );

  // ---------------- reference model ----------------
  typedef struct {
    bit          rd;
    logic [15:0] data;
  } item_t;

  item_t rd_q[$];
  int    vec_q[$];
  int    m_run[CH], m_rep[CH], m_ie[CH], m_done[CH], m_err[CH];
  int    m_csb[CH], m_ctr[CH], m_req[CH];
  bit    m_ack, m_iack;
  int    m_win;
  int    pcount;
  bit    eh[5];
  int    checks = 0;
  int    errors = 0;
  bit    iack_prev = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit any_req();
    for (int n = 0; n < CH; n++) if (m_req[n] != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_tick_next();
`ifdef KW11X_EXT_TICK_EN
    return eh[2] && !eh[3];
`else
    return (pcount % DIV) == DIV - 1;
`endif
  endfunction

  function automatic logic [15:0] m_read(input int ch, input int rg);
    case (rg)
      0: return 16'((m_err[ch] << 15) | (m_done[ch] << 7) | (m_ie[ch] << 6) |
                    (m_rep[ch] << 3) | m_run[ch]);
      1: return 16'(m_csb[ch]);
      2: return 16'(m_ctr[ch]);
      default: return 16'd0;
    endcase
  endfunction

  task automatic model_reset(input bit power);
    for (int n = 0; n < CH; n++) begin
      m_run[n] = 0; m_rep[n] = 0; m_ie[n] = 0; m_done[n] = 0; m_err[n] = 0;
      m_csb[n] = 0; m_ctr[n] = 0; m_req[n] = 0;
    end
    m_ack  = 1'b0;
    m_iack = 1'b0;
    if (power) begin
      pcount = 0;
      for (int k = 0; k < 5; k++) eh[k] = 1'b0;
    end
  endtask

  // Advance the model across one rising clock edge using the driven inputs
  task automatic model_edge();
    bit t, hit, newack, wr, grant, csr_w, csb_w, lo, hi, expire, decr, start;
    int off, ch, rg, win, reload, v;
    int o_run[CH], o_rep[CH], o_ie[CH], o_done[CH], o_csb[CH], o_ctr[CH];
`ifdef KW11X_EXT_TICK_EN
    for (int k = 4; k > 0; k--) eh[k] = eh[k-1];
    eh[0] = ext_tick;
    t = eh[3] && !eh[4];
`else
    t = (pcount % DIV) == DIV - 1;
    pcount++;
`endif
    if (bus_init) begin
      model_reset(1'b0);
      return;
    end
    off    = int'(wb_adr_i) - int'(BASE);
    hit    = (off >= 0) && (off < 8 * CH);
    ch     = off / 8;
    rg     = (off % 8) / 2;
    newack = wb_stb_i && !m_ack && hit;
    wr     = newack && wb_we_i;
    grant  = !m_iack && istb && any_req();
    win    = 0;
    for (int n = CH - 1; n >= 0; n--) if (m_req[n] != 0) win = n;
    o_run = m_run; o_rep = m_rep; o_ie = m_ie; o_done = m_done;
    o_csb = m_csb; o_ctr = m_ctr;
    lo = wb_sel_i[0];
    hi = wb_sel_i[1];
    for (int n = 0; n < CH; n++) begin
      csr_w  = wr && ch == n && rg == 0;
      csb_w  = wr && ch == n && rg == 1;
      expire = t && o_run[n] != 0 && o_ctr[n] == 1;
      decr   = t && o_run[n] != 0 && o_ctr[n] > 1;
      start  = csr_w && lo && wb_dat_i[0] && o_run[n] == 0;
      reload = (o_csb[n] == 0) ? 1 : o_csb[n];
      if (grant && win == n) m_req[n] = 0;
      if (expire) begin
        m_done[n] = 1;
        if (o_done[n] != 0) m_err[n] = 1;
        if (o_rep[n] != 0) m_ctr[n] = reload;
        else begin
          m_ctr[n] = 0;
          m_run[n] = 0;
        end
        if (o_ie[n] != 0) m_req[n] = 1;
      end
      if (decr) m_ctr[n] = o_ctr[n] - 1;
      if (csr_w && lo) begin
        m_run[n]  = int'(wb_dat_i[0]);
        m_rep[n]  = int'(wb_dat_i[3]);
        m_ie[n]   = int'(wb_dat_i[6]);
        m_done[n] = int'(wb_dat_i[7] | expire);
        if (!wb_dat_i[6]) m_req[n] = 0;
      end
      if (start) m_ctr[n] = reload;
      if (csr_w && hi && !wb_dat_i[15] && !(expire && o_done[n] != 0)) m_err[n] = 0;
      if (csb_w) begin
        v = o_csb[n];
        if (lo) v = (v & 'hFF00) | int'(wb_dat_i[7:0]);
        if (hi) v = (v & 'h00FF) | (int'(wb_dat_i[15:8]) << 8);
        m_csb[n] = v & ((1 << CW) - 1);
      end
    end
    if (grant) begin
      m_iack = 1'b1;
      m_win  = win;
      vec_q.push_back(int'(VB) + 4 * win);
    end else if (m_iack && !istb) begin
      m_iack = 1'b0;
    end
    m_ack = newack;
    if (newack) rd_q.push_back('{rd: !wb_we_i, data: m_read(ch, rg)});
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk_p) begin
    item_t it;
    int    ev;
    #1;
    check("ack", int'(wb_ack_o), int'(m_ack));
    check("irq", int'(irq), int'(any_req()));
    check("iack", int'(iack), int'(m_iack));
    check("ivec", int'(ivec), m_iack ? int'(VB) + 4 * m_win : 0);
    if (wb_ack_o) begin
      if (rd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ack_item: got ack with data %0h expected no ack", wb_dat_o);
      end else begin
        it = rd_q.pop_front();
        if (it.rd) check("rdata", int'(wb_dat_o), int'(it.data));
      end
    end else begin
      check("dat_idle", int'(wb_dat_o), 0);
    end
    if (iack && !iack_prev) begin
      if (vec_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL vec_item: got iack vector %0o expected no iack", ivec);
      end else begin
        ev = vec_q.pop_front();
        check("vector", int'(ivec), ev);
      end
    end
    iack_prev = iack;
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk_p);
    model_edge();
    @(negedge clk_p);
`ifdef KW11X_EXT_TICK_EN
    if ($urandom_range(0, 3) == 0) ext_tick = ~ext_tick;
`endif
  endtask

  task automatic bus(input bit we, input logic [15:0] adr,
                     input logic [15:0] dat, input logic [1:0] sel);
    wb_stb_i = 1'b1;
    wb_we_i  = we;
    wb_adr_i = adr;
    wb_dat_i = dat;
    wb_sel_i = sel;
    step();
    step();
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    step();
  endtask

  task automatic intr(input int hold);
    istb = 1'b1;
    repeat (hold) step();
    istb = 1'b0;
    step();
    step();
  endtask

  task automatic do_dclo();
    dclo = 1'b1;
    model_reset(1'b1);
    rd_q.delete();
    vec_q.delete();
    @(posedge clk_p);
    @(negedge clk_p);
    @(posedge clk_p);
    @(negedge clk_p);
    dclo = 1'b0;
  endtask

  task automatic wait_req();
    for (int k = 0; k < 80 && !any_req(); k++) step();
  endtask

  task automatic wait_expiry_tick(input int ch);
    for (int k = 0; k < 100 && !(m_tick_next() && m_ctr[ch] == 1); k++) step();
  endtask

  initial begin
    logic [15:0] adr;
    dclo     = 1'b1;
    bus_init = 1'b0;
    wb_adr_i = '0;
    wb_dat_i = '0;
    wb_we_i  = 1'b0;
    wb_sel_i = 2'b11;
    wb_stb_i = 1'b0;
    istb     = 1'b0;
`ifdef KW11X_EXT_TICK_EN
    ext_tick = 1'b0;
`endif
    model_reset(1'b1);
    @(negedge clk_p);
    @(negedge clk_p);
    dclo = 1'b0;

    // Reset readback of channel 0
    bus(1'b0, BASE,     16'd0, 2'b11);
    bus(1'b0, BASE + 2, 16'd0, 2'b11);
    bus(1'b0, BASE + 4, 16'd0, 2'b11);
    bus(1'b0, BASE + 6, 16'd0, 2'b11);
    bus(1'b0, BASE + 16, 16'd0, 2'b11);

    // One-shot countdown with interrupt enable
    bus(1'b1, BASE + 2, 16'd3, 2'b11);
    bus(1'b1, BASE, 16'o0101, 2'b11);
    for (int k = 0; k < 14; k++) bus(1'b0, (k % 2 == 0) ? BASE + 4 : BASE, 16'd0, 2'b11);

    // Both channels pending, then two vector handshakes
    bus(1'b1, BASE + 10, 16'd2, 2'b11);
    bus(1'b1, BASE + 8, 16'o0101, 2'b11);
    bus(1'b1, BASE + 2, 16'd1, 2'b11);
    bus(1'b1, BASE, 16'o0101, 2'b11);
    repeat (30) step();
    intr(3);
    intr(2);
    repeat (3) step();

    // Repeat mode without interrupts: overrun sets ERR, RUN stays
    bus(1'b1, BASE + 8, 16'o0011, 2'b11);
    for (int k = 0; k < 16; k++) bus(1'b0, BASE + 8 + ((k % 2) * 4), 16'd0, 2'b11);

    // CSR write of 0 on the expiry edge keeps DONE
    bus(1'b1, BASE + 2, 16'd2, 2'b11);
    bus(1'b1, BASE, 16'o0001, 2'b11);
    wait_expiry_tick(0);
    bus(1'b1, BASE, 16'd0, 2'b11);
    bus(1'b0, BASE, 16'd0, 2'b11);
    bus(1'b0, BASE + 4, 16'd0, 2'b11);

    // RUN 0->1 issued on a tick edge loads without decrement
    for (int k = 0; k < 100 && !m_tick_next(); k++) step();
    bus(1'b1, BASE, 16'o0001, 2'b11);
    bus(1'b0, BASE + 4, 16'd0, 2'b11);

    // bus_init in the middle of a vector handshake
    bus(1'b1, BASE + 2, 16'd1, 2'b11);
    bus(1'b1, BASE, 16'o0101, 2'b11);
    wait_req();
    istb = 1'b1;
    for (int k = 0; k < 5 && !m_iack; k++) step();
    bus_init = 1'b1;
    step();
    bus_init = 1'b0;
    istb     = 1'b0;
    step();
    bus(1'b0, BASE, 16'd0, 2'b11);
    bus(1'b0, BASE + 2, 16'd0, 2'b11);

    // dclo in the middle of a vector handshake drops iack at once
    bus(1'b1, BASE + 2, 16'd1, 2'b11);
    bus(1'b1, BASE, 16'o0101, 2'b11);
    wait_req();
    istb = 1'b1;
    for (int k = 0; k < 5 && !m_iack; k++) step();
    dclo = 1'b1;
    #1;
    check("iack_dclo", int'(iack), 0);
    check("ivec_dclo", int'(ivec), 0);
    istb = 1'b0;
    do_dclo();
    bus(1'b0, BASE + 4, 16'd0, 2'b11);

    // Randomized traffic
    for (int op = 0; op < 300; op++) begin
      adr = BASE + 16'(8 * $urandom_range(0, CH - 1));
      case ($urandom_range(0, 7))
        0, 1: begin
          if ($urandom_range(0, 9) == 0)
            adr = ($urandom_range(0, 1) == 0) ? BASE - 16'd2 : BASE + 16'(8 * CH);
          else
            adr = adr + 16'(2 * $urandom_range(0, 3));
          bus(1'b0, adr, 16'd0, 2'b11);
        end
        2: bus(1'b1, adr + 16'd2, 16'($urandom_range(0, 4)) | (($urandom_range(0, 7) == 0) ? 16'h0100 : 16'h0),
               2'($urandom_range(1, 3)));
        3, 4: bus(1'b1, adr, 16'($urandom) & 16'h80C9, 2'($urandom_range(1, 3)));
        5: intr($urandom_range(1, 3));
        6: repeat ($urandom_range(1, 8)) step();
        default: begin
          if ($urandom_range(0, 9) == 0) begin
            bus_init = 1'b1;
            step();
            bus_init = 1'b0;
            step();
          end else begin
            bus(1'b1, adr + 16'd4, 16'($urandom), 2'b11);
          end
        end
      endcase
    end

    repeat (4) step();
    check("rdq_empty", rd_q.size(), 0);
    check("vecq_empty", vec_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
